// File: rtl/link_pkg.sv
// Shared definitions for the link watchdog: state encoding, default
// parameter values and the counter-width helper.
package link_pkg;

  typedef enum logic [2:0] {
    ST_REQ       = 3'd0,
    ST_WAIT_GT   = 3'd1,
    ST_WAIT_LINK = 3'd2,
    ST_STABLE    = 3'd3,
    ST_UP        = 3'd4,
    ST_FAILED    = 3'd5
  } link_state_t;

  localparam int DEF_REQ_CYCLES     = 16;
  localparam int DEF_TIMEOUT_CYCLES = 4096;
  localparam int DEF_STABLE_CYCLES  = 64;
  localparam int DEF_MAX_RETRIES    = 8;
  localparam int DEF_SOFT_WINDOW    = 256;
  localparam int DEF_SOFT_LIMIT     = 16;

  // $clog2 of the parameter, kept at least one bit wide for degenerate values.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/err_rate_window.sv
// Soft-error rate monitor: counts ERR cycles inside a free-running window
// of SOFT_WINDOW cycles and flags OVER on the cycle the count reaches SOFT_LIMIT.
module err_rate_window
  import link_pkg::*;
#(
  parameter int SOFT_WINDOW = DEF_SOFT_WINDOW,
  parameter int SOFT_LIMIT  = DEF_SOFT_LIMIT
) (
  input  logic CLK,
  input  logic RESET,
  input  logic EN,
  input  logic ERR,
  output logic OVER
);

  localparam int WW = cnt_w(SOFT_WINDOW);
  localparam int CW = cnt_w(SOFT_LIMIT);
  localparam logic [WW-1:0] WIN_LAST = WW'(SOFT_WINDOW - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(SOFT_LIMIT - 1);

  logic [WW-1:0] r_win;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_base;

  // The first cycle of every window discards the old count, so an error on
  // that cycle opens the new window at a count of one.
  assign w_cnt_base = (r_win == '0) ? '0 : r_cnt;
  assign OVER       = EN && ERR && (w_cnt_base == CNT_LAST);

  // NOTE: sequential state is written only with non-blocking assignments so
  // every register samples the pre-edge values of the others.
  always_ff @(posedge CLK) begin
    if (RESET || !EN) begin
      r_win <= '0;
      r_cnt <= '0;
    end else begin
      r_win <= (r_win == WIN_LAST) ? '0 : r_win + WW'(1);
      r_cnt <= (ERR && (w_cnt_base != CNT_LAST)) ? w_cnt_base + CW'(1) : w_cnt_base;
    end
  end

endmodule

// File: rtl/link_watchdog.sv
// Aurora link watchdog: requests GT resets, times out link bring-up, checks
// link stability and error rates, and gives up after a bounded number of retries.
module link_watchdog
  import link_pkg::*;
#(
  parameter int REQ_CYCLES     = DEF_REQ_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
  parameter int MAX_RETRIES    = DEF_MAX_RETRIES,
  parameter int SOFT_WINDOW    = DEF_SOFT_WINDOW,
  parameter int SOFT_LIMIT     = DEF_SOFT_LIMIT
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       GT_RESET_ACTIVE,
  input  logic       CHANNEL_UP,
  input  logic       HARD_ERR,
  input  logic       SOFT_ERR,
  output logic       RESET_REQ,
  output logic       LINK_OK,
  output logic       FAIL,
  output logic [3:0] RETRY_CNT,
  output logic [2:0] STATE
);

  localparam int RW = cnt_w(REQ_CYCLES);
  localparam int TW = cnt_w(TIMEOUT_CYCLES);
  localparam int SW = cnt_w(STABLE_CYCLES);
  localparam logic [RW-1:0] REQ_LAST     = RW'(REQ_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [SW-1:0] STABLE_LAST  = SW'(STABLE_CYCLES - 1);
  localparam logic [3:0]    RETRY_MAX    = 4'(MAX_RETRIES);

  link_state_t   r_state;
  logic [RW-1:0] r_req_cnt;
  logic [TW-1:0] r_timer;
  logic [SW-1:0] r_stable_cnt;
  logic [3:0]    r_retry_cnt;
  logic          r_reset_req;
  logic          r_link_ok;
  logic          r_fail;

  link_state_t   w_next_state;
  logic          w_retry;
  logic          w_timeout;
  logic          w_soft_over;
  logic          w_in_link_wait;

  err_rate_window #(
    .SOFT_WINDOW (SOFT_WINDOW),
    .SOFT_LIMIT  (SOFT_LIMIT)
  ) u_err_rate_window (
    .CLK   (CLK),
    .RESET (RESET),
    .EN    (r_state == ST_UP),
    .ERR   (SOFT_ERR),
    .OVER  (w_soft_over)
  );

  assign w_in_link_wait = (r_state == ST_WAIT_LINK) || (r_state == ST_STABLE);
  assign w_timeout      = w_in_link_wait && (r_timer == TIMEOUT_LAST);

  // NOTE: every signal gets a default before the case so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    w_retry      = 1'b0;
    w_next_state = r_state;
    case (r_state)
      ST_REQ:       if (r_req_cnt == REQ_LAST) w_next_state = ST_WAIT_GT;
      ST_WAIT_GT:   if (!GT_RESET_ACTIVE) w_next_state = ST_WAIT_LINK;
      ST_WAIT_LINK: begin
        w_retry = HARD_ERR || w_timeout;
        if (CHANNEL_UP) w_next_state = ST_STABLE;
      end
      ST_STABLE: begin
        w_retry = HARD_ERR || w_timeout;
        if (!CHANNEL_UP)                     w_next_state = ST_WAIT_LINK;
        else if (r_stable_cnt == STABLE_LAST) w_next_state = ST_UP;
      end
      ST_UP:        w_retry = !CHANNEL_UP || HARD_ERR || w_soft_over;
      ST_FAILED:    w_next_state = ST_FAILED;
      default:      w_next_state = ST_REQ;
    endcase
    // A retry cause overrides whatever progress the link made this cycle.
    if (w_retry) w_next_state = (r_retry_cnt < RETRY_MAX) ? ST_REQ : ST_FAILED;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state      <= ST_REQ;
      r_req_cnt    <= '0;
      r_timer      <= '0;
      r_stable_cnt <= '0;
      r_retry_cnt  <= '0;
      r_reset_req  <= 1'b1;
      r_link_ok    <= 1'b0;
      r_fail       <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_req_cnt    <= (r_state == ST_REQ && w_next_state == ST_REQ) ? r_req_cnt + RW'(1) : '0;
      r_stable_cnt <= (r_state == ST_STABLE && w_next_state == ST_STABLE)
                      ? r_stable_cnt + SW'(1) : '0;
      // The timer keeps running across STABLE->WAIT_LINK so a flapping link still times out.
      if (!w_in_link_wait)  r_timer <= '0;
      else if (!w_timeout)  r_timer <= r_timer + TW'(1);
      if (w_retry && w_next_state == ST_REQ) r_retry_cnt <= r_retry_cnt + 4'd1;
      else if (w_next_state == ST_UP)        r_retry_cnt <= '0;
      r_reset_req  <= (w_next_state == ST_REQ);
      r_link_ok    <= (w_next_state == ST_UP);
      r_fail       <= (w_next_state == ST_FAILED);
    end
  end

  assign RESET_REQ = r_reset_req;
  assign LINK_OK   = r_link_ok;
  assign FAIL      = r_fail;
  assign RETRY_CNT = r_retry_cnt;
  assign STATE     = r_state;

endmodule

// File: doc/link_watchdog.md
LINK_WATCHDOG -- requirements
Module: link_watchdog

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset, named CLK and RESET.
REQ-002 SHALL have parameter REQ_CYCLES, default 16: width of each reset request in cycles.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 4096: cycles allowed from GT reset release to CHANNEL_UP.
REQ-004 SHALL have parameter STABLE_CYCLES, default 64: cycles CHANNEL_UP must stay high before the link is declared up.
REQ-005 SHALL have parameter MAX_RETRIES, default 8, range 1..15: retries allowed before permanent fail.
REQ-006 SHALL have parameters SOFT_WINDOW (default 256) and SOFT_LIMIT (default 16): soft-error rate threshold.
REQ-007 SHALL have ports, one per line:
  CLK  in  1  clock
  RESET  in  1  synchronous active-high reset
  GT_RESET_ACTIVE  in  1  downstream GT reset sequencer output still asserted
  CHANNEL_UP  in  1  Aurora channel up
  HARD_ERR  in  1  Aurora hard error, single-cycle or level
  SOFT_ERR  in  1  Aurora soft error, one count per high cycle
  RESET_REQ  out  1  reset request into the GT reset sequencer
  LINK_OK  out  1  link up and stable
  FAIL  out  1  retries exhausted, sticky
  RETRY_CNT  out  4  retries since last successful link-up
  STATE  out  3  current state encoding

Function
REQ-008 SHALL implement states REQ(0), WAIT_GT(1), WAIT_LINK(2), STABLE(3), UP(4) and FAILED(5); STATE SHALL show the encoding.
REQ-009 SHALL register all outputs; no output SHALL be driven combinationally from an input.
REQ-010 In REQ: RESET_REQ=1 for exactly REQ_CYCLES cycles, then go to WAIT_GT.
REQ-011 In WAIT_GT: RESET_REQ=0; go to WAIT_LINK on the first cycle GT_RESET_ACTIVE=0, and clear the timeout timer.
REQ-012 In WAIT_LINK: increment the timer every cycle; go to STABLE when CHANNEL_UP=1; start a retry when the timer reaches TIMEOUT_CYCLES-1.
REQ-013 In STABLE: count consecutive CHANNEL_UP=1 cycles; go to UP after STABLE_CYCLES; if CHANNEL_UP drops, return to WAIT_LINK without clearing the timeout timer.
REQ-014 The timeout timer SHALL also run in STABLE, so a link that flaps through STABLE still hits the timeout.
REQ-015 In UP: LINK_OK=1 and RETRY_CNT cleared to 0; on CHANNEL_UP=0, start a retry.
REQ-016 In UP: count SOFT_ERR cycles in a free-running window of SOFT_WINDOW cycles, clearing the count at window wrap; start a retry when the count reaches SOFT_LIMIT.
REQ-017 If SOFT_ERR=1 on the window-wrap cycle, the new window SHALL start at count 1.
REQ-018 HARD_ERR=1 in WAIT_LINK, STABLE or UP SHALL start a retry; HARD_ERR SHALL be ignored in REQ, WAIT_GT and FAILED.
REQ-019 A retry SHALL go to REQ and increment RETRY_CNT when RETRY_CNT < MAX_RETRIES; otherwise it SHALL go to FAILED.
REQ-020 In FAILED: FAIL=1, RESET_REQ=0, LINK_OK=0; only RESET exits FAILED.
REQ-021 If a retry cause and a success transition occur in the same cycle, the retry SHALL win.
REQ-022 LINK_OK SHALL deassert on the clock edge that leaves UP.
REQ-023 All counters SHALL saturate and never wrap; counter widths SHALL be $clog2 of the parameter.

Reset
REQ-024 While RESET=1: state=REQ, RESET_REQ=1, LINK_OK=0, FAIL=0, RETRY_CNT=0, all timers and counters 0.
REQ-025 After RESET falls, REQ SHALL last a full REQ_CYCLES cycles.
REQ-026 RESET asserted in any state, FAILED included, SHALL take effect at the next clock edge.

Structure
REQ-027 The state encoding and the default parameter values SHALL live in the shared package link_pkg.
REQ-028 The soft-error window counter SHALL be the sub-module err_rate_window (inputs CLK, RESET, EN, ERR; output OVER).
REQ-029 RESET_REQ SHALL be designed to drive the RESET input of the GT reset sequencer, whose reset output in turn drives GT_RESET_ACTIVE.

Verification (REQ_CYCLES=4, TIMEOUT_CYCLES=32, STABLE_CYCLES=8, MAX_RETRIES=2, SOFT_WINDOW=16, SOFT_LIMIT=3)
REQ-030 Clean bring-up: release RESET; GT_RESET_ACTIVE low at cycle 10; CHANNEL_UP high at cycle 15 -> RESET_REQ high for 4 cycles, LINK_OK high at cycle 24 (+/-1 per registering), RETRY_CNT=0.
REQ-031 Timeout: CHANNEL_UP held 0 -> RESET_REQ pulses 3 times total, then FAIL=1, STATE=5, RETRY_CNT=2.
REQ-032 Flap: CHANNEL_UP high 5 cycles, low 1, high -> STATE returns to 2 then 3; LINK_OK only after 8 consecutive high cycles.
REQ-033 Soft errors: in UP, 3 SOFT_ERR pulses inside one 16-cycle window -> retry, RETRY_CNT=1; 2 pulses per window -> no retry.
REQ-034 Hard error plus RESET: HARD_ERR in UP -> STATE=0; RESET asserted while in FAILED -> FAIL=0, RESET_REQ=1 on the next edge.
